// File: rtl/shift_pkg.sv
// Shared types and constants for the shift request sequencer.
package shift_pkg;

  localparam int unsigned DW       = 8;
  localparam int unsigned SHAMT_W  = 5;
  localparam int unsigned STEP_MAX = 7;
  localparam int unsigned STEP_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One accepted shift command.
  typedef struct packed {
    logic [DW-1:0]      din;
    logic [SHAMT_W-1:0] shamt;
    logic               lr;
    logic               al;
    logic               id;
  } shift_cmd_t;

endpackage

// File: rtl/barrel_register.sv
// 8-bit combinational barrel shifter, 0..7 positions per pass.
module barrel_register
  import shift_pkg::*;
(
  input  logic [DW-1:0]     i_din,
  input  logic [STEP_W-1:0] i_amt,
  input  logic              i_lr,
  input  logic              i_al,
  output logic [DW-1:0]     o_dout
);

  // Left, arithmetic right or logical right by i_amt.
  always_comb begin
    o_dout = i_din;
    if (i_lr) begin
      o_dout = i_din << i_amt;
    end else if (i_al) begin
      o_dout = DW'($signed(i_din) >>> i_amt);
    end else begin
      o_dout = i_din >> i_amt;
    end
  end

endmodule

// File: rtl/shift_req_sequencer.sv
// Shares one 8-bit barrel shifter between two requesters; long shifts iterate
// in passes of up to STEP_MAX positions.
module shift_req_sequencer
  import shift_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DW-1:0]      req0_din,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic               req0_lr,
  input  logic               req0_al,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DW-1:0]      req1_din,
  input  logic [SHAMT_W-1:0] req1_shamt,
  input  logic               req1_lr,
  input  logic               req1_al,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [DW-1:0]      resp_data,
  output logic               resp_id
);

  state_t             r_state;
  logic [DW-1:0]      r_acc;
  logic [SHAMT_W-1:0] r_rem;
  logic               r_lr;
  logic               r_al;
  logic               r_id;
  logic               r_rr_ptr;

  logic               w_gnt0;
  logic               w_gnt1;
  shift_cmd_t         w_cmd;
  logic [STEP_W-1:0]  w_step;
  logic [SHAMT_W-1:0] w_rem_next;
  logic [DW-1:0]      w_shift;

  // Round-robin grant, only offered while idle and out of reset.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if ((r_state == ST_IDLE) && !rst) begin
      if (req0_valid && (!req1_valid || !r_rr_ptr)) begin
        w_gnt0 = 1'b1;
      end else if (req1_valid) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  // Command of the granted requester.
  always_comb begin
    if (w_gnt1) begin
      w_cmd = '{din: req1_din, shamt: req1_shamt, lr: req1_lr, al: req1_al, id: 1'b1};
    end else begin
      w_cmd = '{din: req0_din, shamt: req0_shamt, lr: req0_lr, al: req0_al, id: 1'b0};
    end
  end

  // Per-pass step: min(remaining, STEP_MAX).
  always_comb begin
    if (r_rem > SHAMT_W'(STEP_MAX)) begin
      w_step = STEP_W'(STEP_MAX);
    end else begin
      w_step = r_rem[STEP_W-1:0];
    end
    w_rem_next = r_rem - SHAMT_W'(w_step);
  end

  barrel_register u_shifter (
    .i_din  (r_acc),
    .i_amt  (w_step),
    .i_lr   (r_lr),
    .i_al   (r_al),
    .o_dout (w_shift)
  );

  // Sequencer FSM with registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_rem      <= '0;
      r_lr       <= 1'b0;
      r_al       <= 1'b0;
      r_id       <= 1'b0;
      r_rr_ptr   <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_acc    <= w_cmd.din;
            r_rem    <= w_cmd.shamt;
            r_lr     <= w_cmd.lr;
            r_al     <= w_cmd.al;
            r_id     <= w_cmd.id;
            r_rr_ptr <= ~w_cmd.id;
            if (w_cmd.shamt == '0) begin
              r_state    <= ST_DONE;
              resp_valid <= 1'b1;
              resp_data  <= w_cmd.din;
              resp_id    <= w_cmd.id;
            end else begin
              r_state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          r_acc <= w_shift;
          r_rem <= w_rem_next;
          if (w_rem_next == '0) begin
            r_state    <= ST_DONE;
            resp_valid <= 1'b1;
            resp_data  <= w_shift;
            resp_id    <= r_id;
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            r_state    <= ST_IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_req_sequencer.sv
// Self-checking bench for shift_req_sequencer: table vectors plus
// hand-written arbitration, backpressure and async-reset sequences.
module tb_shift_req_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req0_lr, req0_al;
  logic [7:0] req0_din;
  logic [4:0] req0_shamt;
  logic       req1_valid, req1_ready, req1_lr, req1_al;
  logic [7:0] req1_din;
  logic [4:0] req1_shamt;
  logic       resp_valid, resp_ready, resp_id;
  logic [7:0] resp_data;

  shift_req_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_din   (req0_din),
    .req0_shamt (req0_shamt),
    .req0_lr    (req0_lr),
    .req0_al    (req0_al),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_din   (req1_din),
    .req1_shamt (req1_shamt),
    .req1_lr    (req1_lr),
    .req1_al    (req1_al),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] din;
    logic [4:0] shamt;
    logic       lr;
    logic       al;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       id;
    int         gcyc;
    int         lat;
  } sb_t;

  sb_t        sb[$];
  sb_t        e;
  int         gnt_ids[$];
  int         gnt_cycs[$];
  int         hs_cycs[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         n_gnt = 0;
  int         n_resp = 0;
  int         first_cyc = 0;
  logic       prev_valid = 1'b0;
  logic       prev_hs = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_id = 1'b0;
  logic [7:0] last_rdata = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a single direct shift of the original operand.
  function automatic logic [7:0] model(input logic [7:0] d, input logic [4:0] s,
                                       input logic lr, input logic al);
    logic [7:0] r;
    if (lr) r = d << s;
    else if (al) r = 8'($signed(d) >>> s);
    else r = d >> s;
    return r;
  endfunction

  task automatic note_grant(input int id, input logic [7:0] d, input logic [4:0] s,
                            input logic lr, input logic al);
    sb_t n;
    n.data = model(d, s, lr, al);
    n.id   = id[0];
    n.gcyc = cyc;
    n.lat  = 1 + (int'(s) + 6) / 7;
    sb.push_back(n);
    gnt_ids.push_back(id);
    gnt_cycs.push_back(cyc);
    n_gnt++;
  endtask

  always @(posedge clk) cyc++;

  // Monitor: grants feed the scoreboard, responses are checked against it.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (req0_ready || req1_ready) chk("ready_exclusive", 32'(req0_ready && req1_ready), 32'd0);
      if (req0_valid && req0_ready) note_grant(0, req0_din, req0_shamt, req0_lr, req0_al);
      if (req1_valid && req1_ready) note_grant(1, req1_din, req1_shamt, req1_lr, req1_al);
      if (resp_valid && !prev_valid) first_cyc = cyc;
      if (prev_valid && !prev_hs) begin
        chk("hold_valid", 32'(resp_valid), 32'd1);
        chk("hold_data", 32'(resp_data), 32'(prev_data));
        chk("hold_id", 32'(resp_id), 32'(prev_id));
      end
      if (prev_hs) chk("idle_after_hs", 32'(resp_valid), 32'd0);
      if (resp_valid) chk("ready_low_in_done", 32'({req0_ready, req1_ready}), 32'd0);
      if (resp_valid && resp_ready) begin
        n_resp++;
        hs_cycs.push_back(cyc);
        last_rdata = resp_data;
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_resp: got data 0x%0h id %0d, expected no response", resp_data, resp_id);
        end else begin
          e = sb.pop_front();
          chk("resp_data", 32'(resp_data), 32'(e.data));
          chk("resp_id", 32'(resp_id), 32'(e.id));
          chk("resp_latency", 32'(first_cyc - e.gcyc), 32'(e.lat));
        end
      end
      prev_valid = resp_valid;
      prev_hs    = resp_valid && resp_ready;
      prev_data  = resp_data;
      prev_id    = resp_id;
    end
  end

  // Drive one request and hold it until granted; call at posedge + #1.
  task automatic issue(input vec_t v, output int waited);
    logic rdy;
    waited = 0;
    if (v.id == 0) begin
      req0_din = v.din; req0_shamt = v.shamt; req0_lr = v.lr; req0_al = v.al; req0_valid = 1'b1;
    end else begin
      req1_din = v.din; req1_shamt = v.shamt; req1_lr = v.lr; req1_al = v.al; req1_valid = 1'b1;
    end
    forever begin
      @(negedge clk);
      waited++;
      rdy = (v.id == 0) ? req0_ready : req1_ready;
      if (rdy) break;
      if (waited > 200) begin
        chk("grant_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    req0_valid = (v.id == 0) ? 1'b0 : req0_valid;
    req1_valid = (v.id == 1) ? 1'b0 : req1_valid;
  endtask

  task automatic wait_resp(input int target);
    int k;
    k = 0;
    while (n_resp < target && k < 300) begin
      @(posedge clk);
      k++;
    end
    chk("resp_arrived", 32'(n_resp >= target), 32'd1);
  endtask

  vec_t tbl[11];
  vec_t v;
  int   w;
  int   base;
  int   k;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0, 8'h96, 5'd3,  1'b0, 1'b1, 8'hF2};
    tbl[1]  = '{0, 8'h96, 5'd3,  1'b0, 1'b0, 8'h12};
    tbl[2]  = '{0, 8'h96, 5'd3,  1'b1, 1'b0, 8'hB0};
    tbl[3]  = '{1, 8'h80, 5'd10, 1'b0, 1'b1, 8'hFF};
    tbl[4]  = '{1, 8'h80, 5'd10, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{0, 8'h01, 5'd7,  1'b1, 1'b0, 8'h80};
    tbl[6]  = '{0, 8'h5A, 5'd0,  1'b0, 1'b0, 8'h5A};
    tbl[7]  = '{0, 8'h7F, 5'd31, 1'b0, 1'b1, 8'h00};
    tbl[8]  = '{1, 8'hC3, 5'd8,  1'b1, 1'b0, 8'h00};
    tbl[9]  = '{1, 8'hB4, 5'd13, 1'b0, 1'b1, 8'hFF};
    tbl[10] = '{1, 8'hA5, 5'd2,  1'b1, 1'b1, 8'h94};

    rst = 1'b1;
    resp_ready = 1'b1;
    req0_valid = 1'b0; req0_din = 8'h00; req0_shamt = 5'd0; req0_lr = 1'b0; req0_al = 1'b0;
    req1_valid = 1'b0; req1_din = 8'h00; req1_shamt = 5'd0; req1_lr = 1'b0; req1_al = 1'b0;
    #12;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Both requesters held valid from reset: grants alternate 0,1,0,1.
    req0_din = 8'h96; req0_shamt = 5'd3;  req0_lr = 1'b0; req0_al = 1'b1; req0_valid = 1'b1;
    req1_din = 8'h80; req1_shamt = 5'd10; req1_lr = 1'b0; req1_al = 1'b1; req1_valid = 1'b1;
    k = 0;
    while (n_gnt < 4 && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("arb_grant_count", 32'(n_gnt), 32'd4);
    wait_resp(4);
    if (gnt_ids.size() >= 4 && hs_cycs.size() >= 3) begin
      for (int i = 0; i < 4; i++) chk("arb_order", 32'(gnt_ids[i]), 32'(i % 2));
      for (int i = 1; i < 4; i++) chk("arb_next_idle_grant", 32'(gnt_cycs[i]), 32'(hs_cycs[i-1] + 1));
    end else begin
      chk("arb_history_size", 32'(gnt_ids.size()), 32'd4);
    end

    // Table vectors.
    for (int i = 0; i < 11; i++) begin
      #1;
      base = n_resp;
      issue(tbl[i], w);
      wait_resp(base + 1);
      chk("tbl_result", 32'(last_rdata), 32'(tbl[i].exp));
    end

    // Backpressure: response held for 5 cycles while req0 waits.
    #1;
    resp_ready = 1'b0;
    base = n_resp;
    v = '{1, 8'h96, 5'd5, 1'b0, 1'b1, 8'hFC};
    issue(v, w);
    k = 0;
    while (!resp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("bp_valid_seen", 32'(resp_valid), 32'd1);
    #1;
    req0_din = 8'h3C; req0_shamt = 5'd2; req0_lr = 1'b1; req0_al = 1'b0; req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_data", 32'(resp_data), 32'hFC);
      chk("bp_id", 32'(resp_id), 32'd1);
      chk("bp_ready0", 32'(req0_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    k = n_gnt;
    wait_resp(base + 1);
    w = 0;
    while (n_gnt == k && w < 50) begin
      @(posedge clk);
      w++;
    end
    #1;
    req0_valid = 1'b0;
    wait_resp(base + 2);
    chk("bp_followup", 32'(last_rdata), 32'hF0);

    // Async reset in the middle of a multi-pass command.
    #1;
    v = '{0, 8'hA5, 5'd20, 1'b0, 1'b1, 8'hFF};
    issue(v, w);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_resp_valid", 32'(resp_valid), 32'd0);
    chk("arst_resp_data", 32'(resp_data), 32'd0);
    chk("arst_resp_id", 32'(resp_id), 32'd0);
    sb.delete();
    base = n_resp;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("arst_no_resp", 32'(n_resp), 32'(base));
    v = '{1, 8'h3C, 5'd4, 1'b0, 1'b0, 8'h03};
    issue(v, w);
    chk("arst_first_idle_grant", 32'(w), 32'd1);
    wait_resp(base + 1);
    chk("arst_followup", 32'(last_rdata), 32'h03);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
